// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Leading-zero blanking is enabled by defining BIN2BCD_BLANK_EN.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Decimal digits of 2^bin_w - 1, i.e. floor(bin_w * log10(2)) + 1.
  // 2^bin_w is never a power of ten, so the floor is exact.
  function automatic int digits_needed(input int bin_w);
    longint scaled;
    scaled = longint'(bin_w) * 64'sd301029995;
    return int'(scaled / 64'sd1000000000) + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 before the shift.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Largest corrected value is 9 + 3 = 12, so 4 bits never overflow.
  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble shift per clock.
// Define BIN2BCD_BLANK_EN to show leading zero digits as BCD_BLANK (4'hF).
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [1:0]            dbg_state_o
);

  // Handshake: start is taken at a rising edge only when ready=1 in that
  // cycle; bin is sampled at that same edge. done is high for exactly one
  // cycle, and bcd is valid from that cycle until the next done.

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  if (BIN_W < 1) begin : g_bad_width
    $error("bin2bcd_seq: BIN_W must be at least 1");
  end
  if (DIGITS < digits_needed(BIN_W)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small to hold 2^BIN_W-1");
  end

  state_e              state_q, state_d;
  logic [BIN_W-1:0]    shreg_q, shreg_d;
  logic [4*DIGITS-1:0] dig_q, dig_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;

  logic [4*DIGITS-1:0] dig_adj;
  logic [4*DIGITS-1:0] dig_next;
  logic [BIN_W-1:0]    shreg_next;
  logic [4*DIGITS-1:0] bcd_fmt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (dig_q[4*g +: 4]),
      .digit_o (dig_adj[4*g +: 4])
    );
  end

  // {digits, shreg} << 1 after correction; shreg MSB feeds digit 0 LSB.
  assign dig_next   = {dig_adj[4*DIGITS-2:0], shreg_q[BIN_W-1]};
  assign shreg_next = shreg_q << 1;

`ifdef BIN2BCD_BLANK_EN
  always_comb begin
    logic lead;
    bcd_fmt = dig_next;
    lead    = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (dig_next[4*i +: 4] == 4'd0)) begin
        bcd_fmt[4*i +: 4] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign bcd_fmt = dig_next;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          shreg_d = bin;
          dig_d   = '0;
          cnt_d   = CNT_W'(BIN_W - 1);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        shreg_d = shreg_next;
        dig_d   = dig_next;
        if (cnt_q == '0) begin
          state_d = DONE;
          bcd_d   = bcd_fmt;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  assign ready       = (state_q != SHIFT);
  assign done        = (state_q == DONE);
  assign bcd         = bcd_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed table-driven bench for bin2bcd_seq across several widths,
// plus hand-written back-to-back, ignored-start and mid-conversion reset cases.
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

`ifdef BIN2BCD_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT instances ----------------
  // idx 0: 8b/3 digits, idx 1: 7b/3, idx 2: 16b/5, idx 3: 1b/1
  logic        start_v [4];
  logic [15:0] bin_v   [4];
  logic        rdy8, rdy7, rdy16, rdy1;
  logic        dn8, dn7, dn16, dn1;
  logic [11:0] bcd8, bcd7;
  logic [19:0] bcd16;
  logic [3:0]  bcd1;
  logic [1:0]  dbg8, dbg7, dbg16, dbg1;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .bin(bin_v[0][7:0]),
    .ready(rdy8), .done(dn8), .bcd(bcd8), .dbg_state_o(dbg8));
  bin2bcd_seq #(.BIN_W(7), .DIGITS(3)) dut7 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .bin(bin_v[1][6:0]),
    .ready(rdy7), .done(dn7), .bcd(bcd7), .dbg_state_o(dbg7));
  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .bin(bin_v[2]),
    .ready(rdy16), .done(dn16), .bcd(bcd16), .dbg_state_o(dbg16));
  bin2bcd_seq #(.BIN_W(1), .DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .bin(bin_v[3][0:0]),
    .ready(rdy1), .done(dn1), .bcd(bcd1), .dbg_state_o(dbg1));

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [19:0] exp_q[$];
  logic [19:0] last_bcd [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] get_bcd(input int idx);
    case (idx)
      0:       return {8'h0, bcd8};
      1:       return {8'h0, bcd7};
      2:       return bcd16;
      default: return {16'h0, bcd1};
    endcase
  endfunction

  function automatic logic get_done(input int idx);
    case (idx)
      0:       return dn8;
      1:       return dn7;
      2:       return dn16;
      default: return dn1;
    endcase
  endfunction

  function automatic logic get_ready(input int idx);
    case (idx)
      0:       return rdy8;
      1:       return rdy7;
      2:       return rdy16;
      default: return rdy1;
    endcase
  endfunction

  function automatic int width_of(input int idx);
    case (idx)
      0:       return 8;
      1:       return 7;
      2:       return 16;
      default: return 1;
    endcase
  endfunction

  // ---------------- driver ----------------
  // One conversion: checks latency (cycle 1 = cycle after accepting edge),
  // result, ready in DONE, bcd hold while busy, and the one-cycle done pulse.
  task automatic run_conv(input int idx, input logic [15:0] b, input string nm);
    int          cyc;
    bit          hold_ok;
    logic [19:0] exp;
    exp = exp_q.pop_front();
    cyc = 0;
    @(negedge clk);
    while (!get_ready(idx) && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    start_v[idx] = 1'b1;
    bin_v[idx]   = b;
    @(posedge clk);
    #1;
    start_v[idx] = 1'b0;
    bin_v[idx]   = ~b;
    hold_ok = 1'b1;
    cyc     = 1;
    @(negedge clk);
    while (!get_done(idx) && cyc < 100) begin
      if (get_bcd(idx) !== last_bcd[idx]) hold_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({nm, " latency"}, cyc, width_of(idx) + 1);
    check({nm, " bcd"}, get_bcd(idx), exp);
    check({nm, " ready in done"}, get_ready(idx), 1);
    check({nm, " bcd hold"}, hold_ok, 1);
    last_bcd[idx] = exp;
    @(negedge clk);
    check({nm, " done pulse"}, get_done(idx), 0);
  endtask

  typedef struct {
    int          idx;
    logic [15:0] bin;
    logic [19:0] exp_plain;
    logic [19:0] exp_blank;
    string       name;
  } vec_t;

  vec_t tbl [14];

  // ---------------- main sequence ----------------
  initial begin
    int          t1, t2, n_done;
    logic [19:0] r1, r2;

    tbl[0]  = '{0, 16'd255,   20'h00255, 20'h00255, "b8 255"};
    tbl[1]  = '{0, 16'd0,     20'h00000, 20'h00FF0, "b8 0"};
    tbl[2]  = '{0, 16'd5,     20'h00005, 20'h00FF5, "b8 5"};
    tbl[3]  = '{0, 16'd40,    20'h00040, 20'h00F40, "b8 40"};
    tbl[4]  = '{0, 16'd100,   20'h00100, 20'h00100, "b8 100"};
    tbl[5]  = '{0, 16'd173,   20'h00173, 20'h00173, "b8 173"};
    tbl[6]  = '{1, 16'd127,   20'h00127, 20'h00127, "b7 127"};
    tbl[7]  = '{1, 16'd0,     20'h00000, 20'h00FF0, "b7 0"};
    tbl[8]  = '{2, 16'd65535, 20'h65535, 20'h65535, "b16 65535"};
    tbl[9]  = '{2, 16'd10000, 20'h10000, 20'h10000, "b16 10000"};
    tbl[10] = '{2, 16'd9,     20'h00009, 20'hFFFF9, "b16 9"};
    tbl[11] = '{2, 16'd4096,  20'h04096, 20'hF4096, "b16 4096"};
    tbl[12] = '{3, 16'd1,     20'h00001, 20'h00001, "b1 1"};
    tbl[13] = '{3, 16'd0,     20'h00000, 20'h00000, "b1 0"};

    for (int i = 0; i < 4; i++) begin
      start_v[i]  = 1'b0;
      bin_v[i]    = '0;
      last_bcd[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset bcd", bcd8, 0);
    check("reset done", dn8, 0);
    check("reset ready", rdy8, 1);
    check("reset dbg idle", {dbg8, dbg7, dbg16, dbg1}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(BLANK ? tbl[i].exp_blank : tbl[i].exp_plain);
      run_conv(tbl[i].idx, tbl[i].bin, tbl[i].name);
    end

    // start held high: accepted in IDLE and again in the DONE cycle
    @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 16'd99;
    @(posedge clk);
    #1;
    bin_v[0] = 16'd200;
    t1 = -1; t2 = -1; n_done = 0; r1 = '0; r2 = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (dn8) begin
        n_done++;
        if (t1 < 0) begin
          t1 = c; r1 = {8'h0, bcd8};
        end else if (t2 < 0) begin
          t2 = c; r2 = {8'h0, bcd8};
          start_v[0] = 1'b0;
        end
      end
    end
    start_v[0] = 1'b0;
    check("b2b first latency", t1, 9);
    check("b2b spacing", t2 - t1, 9);
    check("b2b first bcd", r1, BLANK ? 20'h00F99 : 20'h00099);
    check("b2b second bcd", r2, 20'h00200);
    check("b2b done count", n_done, 2);

    // start pulse during SHIFT must be ignored
    @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 16'd50;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    bin_v[0]   = 16'd0;
    t1 = -1; n_done = 0; r1 = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (dn8) begin
        n_done++;
        if (t1 < 0) begin
          t1 = c; r1 = {8'h0, bcd8};
        end
      end
      if (c == 3) begin
        start_v[0] = 1'b1;
        bin_v[0]   = 16'd77;
      end else if (c == 4) begin
        start_v[0] = 1'b0;
      end
    end
    check("ignored start latency", t1, 9);
    check("ignored start bcd", r1, BLANK ? 20'h00F50 : 20'h00050);
    check("ignored start done count", n_done, 1);

    // reset in the middle of a conversion
    @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 16'd173;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid reset bcd", bcd8, 0);
    check("mid reset done", dn8, 0);
    check("mid reset ready", rdy8, 1);
    rst_n  = 1'b1;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dn8) n_done++;
    end
    check("aborted conversion done", n_done, 0);
    check("post reset bcd", bcd8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble). It performs one shift per clock, which keeps logic depth flat for wide inputs. A start/ready/done handshake replaces the purely combinational converter. It sits between counters or score registers and the 7-segment display drivers, and supports arbitrary input width and digit count.

Parameters:
BIN_W, 8, input binary width in bits (>= 1)
DIGITS, 3, number of BCD digits produced; must satisfy 10^DIGITS > 2^BIN_W - 1, otherwise elaboration fails

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
start  input  1  request conversion of bin; accepted only in a cycle where ready=1
bin  input  BIN_W  unsigned binary operand, sampled in the accepting cycle only
ready  output  1  block can accept start this cycle
done  output  1  one-cycle pulse; bcd is valid and stable from this cycle on
bcd  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0], most significant digit at top

Behaviour:
- Reset (rst_n=0 at a clock edge), whether idle or mid-conversion:
  - state=IDLE, bcd=0, done=0, ready=1 from the next cycle.
  - Any in-flight conversion is discarded.
- States:
  - IDLE: ready=1. start=1 -> latch bin into shift register, clear digit accumulator, bit counter=BIN_W-1, go to SHIFT.
  - SHIFT: ready=0. Each cycle:
    - Every digit >= 5 gets +3 (4-bit, no carry out; a corrected digit never exceeds 12).
    - Then {digits, shreg} shifts left by 1, MSB of shreg entering digit 0 LSB.
    - When the counter is 0 on this cycle, go to DONE; otherwise decrement the counter.
  - DONE: done=1, bcd register loaded with the final digits, ready=1.
    - start=1 here is accepted exactly as in IDLE and goes to SHIFT.
    - Otherwise go to IDLE.
- Latency: start accepted at edge N -> done=1 during cycle N+BIN_W+1. Throughput is one conversion per BIN_W+1 cycles back-to-back.
- bcd holds the previous result throughout a conversion and changes only on entry to DONE.
- start while ready=0 is ignored: no queuing, no error flag. bin changes while busy have no effect.
- bin=0 -> bcd=0.
- Max input 2^BIN_W-1 must convert exactly, with no truncation of the top digit.
- BIN_W=1 is legal: latency 2 cycles.
- The upper DIGITS-needed digits that are never reachable stay 0.

Optional Feature:
Macro BIN2BCD_BLANK_EN.
- Defined: leading-zero blanking applied when bcd is loaded in DONE. Every digit above the most significant non-zero digit is output as 4'hF, which display drivers treat as segments-off. Digit 0 is never blanked, so value 0 shows as 0.
- Undefined: plain zero-padded BCD, and the blanking logic is absent.
- Latency and handshake are identical in both cases.

Decomposition:
- Package bin2bcd_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - BCD_BLANK constant (4'hF)
  - constant function digits_needed(BIN_W), used for the parameter-legality assertion
- One natural sub-module: bcd_digit_adj, a combinational per-digit "if >=5 add 3" cell. It is instantiated DIGITS times via generate.

Test Plan:
- BIN_W=8, DIGITS=3; start with bin=8'd255 -> done pulses 9 cycles after the accepting edge, bcd=12'h255, ready back to 1.
- BIN_W=7, DIGITS=3; bin=7'd127 then bin=7'd0 -> bcd=12'h127, then 12'h000. Check bcd holds 12'h127 during the second conversion.
- Back-to-back: start held high, bins 8'd99 then 8'd200 -> starts accepted in IDLE and in the DONE cycle. Two done pulses 9 cycles apart with bcd=12'h099 then 12'h200. A start pulse during SHIFT is ignored.
- Reset mid-conversion: start bin=8'd173, assert rst_n=0 at cycle 4 -> next cycle bcd=0, done=0, ready=1. No done pulse from the aborted conversion.
- BIN_W=16, DIGITS=5; bin=16'd65535 -> bcd=20'h65535 after 17 cycles. bin=16'd10000 -> 20'h10000.
- With BIN2BCD_BLANK_EN: bin=8'd5 -> bcd=12'hFF5; bin=8'd40 -> 12'hF40; bin=8'd0 -> 12'hFF0.
